crt_mem_arb: RTL and testbench
==============================

CRT_MEM_ARB -- requirements
Module: crt_mem_arb

Interface
REQ-001 SHALL have parameter CRT_BURST, default 16, words per CRT half-FIFO refill (range 1..31).
REQ-002 SHALL have parameter DE_BURST, default 8, words per drawing-engine burst (range 1..31).
REQ-003 SHALL have parameter STARVE, default 32, mem_clk cycles a waiting de_req tolerates before promotion.
REQ-004 Ports, clock and reset first:
- mem_clk  in  1  sole clock.
- hreset  in  1  asynchronous, active-high reset.
- crt_req  in  1  a CRT FIFO half is writeable.
- crt_urgent  in  1  both CRT FIFO halves are empty.
- sync_crt_line_end  in  1  line-end, already synchronised to mem_clk.
- cpu_req  in  1  host single-word request.
- de_req  in  1  drawing-engine burst request.
- mem_rdy  in  1  memory controller accepts a burst start.
- mem_dval  in  1  one data word returned this cycle.
- crt_gnt / cpu_gnt / de_gnt  out  1 each  one-hot owner grant.
- mem_start  out  1  one-cycle burst-start strobe.
- mem_len  out  5  burst length in words, valid with mem_start.
- crt_ff_write  out  1  CRT FIFO write strobe.
- burst_done  out  1  one-cycle end-of-burst pulse.
- busy  out  1  arbiter not in IDLE.

Function
REQ-005 SHALL register all outputs; grants SHALL be one-hot or all zero.
REQ-006 SHALL implement states IDLE, START, XFER, DONE.
REQ-007 In IDLE with any request, the winner SHALL be latched and the FSM SHALL go to START next cycle; with no request it SHALL stay in IDLE.
REQ-008 Priority SHALL be, highest first:
- crt_urgent
- de_req with starve count >= STARVE
- cpu_req
- crt_req
- de_req
REQ-009 Burst length SHALL be CRT_BURST for the CRT owner, 1 for the CPU owner, and DE_BURST for the DE owner.
REQ-010 The winner's grant SHALL assert on entry to START and hold through DONE.
REQ-011 In START, mem_start SHALL assert for exactly one cycle when mem_rdy=1, with mem_len driven; the FSM SHALL then go to XFER.
REQ-012 While mem_rdy=0, the FSM SHALL wait in START with mem_start=0.
REQ-013 In XFER, a 5-bit word counter SHALL increment on each mem_dval.
REQ-014 When mem_dval arrives with count = len-1, the FSM SHALL go to DONE.
REQ-015 Cycles without mem_dval SHALL not advance the counter and SHALL have no timeout.
REQ-016 crt_ff_write SHALL equal mem_dval registered one cycle, gated by CRT ownership and by the abort flag being clear.
REQ-017 sync_crt_line_end during a CRT-owned START or XFER SHALL set the abort flag; the burst SHALL still drain all returned words, with crt_ff_write suppressed.
REQ-018 The abort flag SHALL clear in DONE.
REQ-019 sync_crt_line_end while in IDLE SHALL block a CRT win in that cycle only.
REQ-020 DONE SHALL last one cycle: burst_done=1, grants cleared on exit, return to IDLE.
REQ-021 The next arbitration SHALL occur no earlier than the cycle after IDLE is re-entered.
REQ-022 Starve counter:
- increments each cycle de_req=1 and DE is not the owner;
- saturates at STARVE;
- clears when DE wins or de_req=0.
REQ-023 Requests arriving or dropping mid-burst SHALL not affect the current owner.
REQ-024 mem_dval in IDLE or START SHALL be ignored and SHALL not produce crt_ff_write.
REQ-025 busy SHALL be 1 in START, XFER and DONE.

Reset
REQ-026 While hreset=1, the FSM SHALL be in IDLE and the counter, starve count and abort flag SHALL be 0.
REQ-027 While hreset=1, every output SHALL be 0, including mem_len=0.
REQ-028 hreset asserted mid-burst SHALL abandon the burst immediately; no burst_done SHALL be issued.
REQ-029 The first arbitration after reset SHALL occur in the first mem_clk edge after hreset deasserts.

Verification
REQ-030 Scenario: crt_req=1, mem_rdy=1, 16 consecutive mem_dval. Required: crt_gnt, one mem_start with mem_len=16, 16 crt_ff_write pulses, burst_done, busy=0 afterwards.
REQ-031 Scenario: cpu_req, crt_req and de_req asserted together in IDLE. Required: cpu_gnt first, then crt_gnt, then de_gnt with mem_len=8.
REQ-032 Scenario: de_req held while cpu_req is re-asserted continuously. Required: once the starve count reaches 32, de_gnt is granted ahead of cpu_req; the starve count then reads 0.
REQ-033 Scenario: sync_crt_line_end pulsed after the 5th word of a CRT burst. Required: exactly 5 crt_ff_write pulses, FSM still waits for 16 mem_dval, then burst_done.
REQ-034 Scenario: mem_rdy held 0 for 10 cycles in START. Required: mem_start=0 throughout, grant held, then a single mem_start when mem_rdy rises.
REQ-035 Scenario: hreset pulsed during XFER. Required: all outputs 0 at once, no burst_done, a clean arbitration after release.

Source files
------------

// File: rtl/crt_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : crt_mem_arb_if
// Brief    : Request/grant and memory burst handshake bundle for crt_mem_arb.
// Revision : 1.0
// ============================================================================
interface crt_mem_arb_if;
    logic       crt_req;
    logic       crt_urgent;
    logic       sync_crt_line_end;
    logic       cpu_req;
    logic       de_req;
    logic       mem_rdy;
    logic       mem_dval;
    logic       crt_gnt;
    logic       cpu_gnt;
    logic       de_gnt;
    logic       mem_start;
    logic [4:0] mem_len;
    logic       crt_ff_write;
    logic       burst_done;
    logic       busy;

    // Requestor / memory side
    modport master (
        output crt_req, crt_urgent, sync_crt_line_end, cpu_req, de_req,
        output mem_rdy, mem_dval,
        input  crt_gnt, cpu_gnt, de_gnt, mem_start, mem_len,
        input  crt_ff_write, burst_done, busy
    );

    // Arbiter side
    modport slave (
        input  crt_req, crt_urgent, sync_crt_line_end, cpu_req, de_req,
        input  mem_rdy, mem_dval,
        output crt_gnt, cpu_gnt, de_gnt, mem_start, mem_len,
        output crt_ff_write, burst_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/crt_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : crt_mem_arb
// Brief    : CRT / CPU / drawing-engine memory burst arbiter with DE starvation
//            promotion and CRT line-end abort.
// Revision : 1.0
// ============================================================================
module crt_mem_arb #(
    parameter int CRT_BURST = 16,
    parameter int DE_BURST  = 8,
    parameter int STARVE    = 32
) (
    input  logic         mem_clk,
    input  logic         hreset,
    crt_mem_arb_if.slave bus
);
    localparam int                c_SW         = $clog2(STARVE + 1);
    localparam logic [1:0]        c_IDLE       = 2'd0;
    localparam logic [1:0]        c_START      = 2'd1;
    localparam logic [1:0]        c_XFER       = 2'd2;
    localparam logic [1:0]        c_DONE       = 2'd3;
    localparam logic [1:0]        c_OWN_NONE   = 2'd0;
    localparam logic [1:0]        c_OWN_CRT    = 2'd1;
    localparam logic [1:0]        c_OWN_CPU    = 2'd2;
    localparam logic [1:0]        c_OWN_DE     = 2'd3;
    localparam logic [4:0]        c_CRT_LEN    = CRT_BURST[4:0];
    localparam logic [4:0]        c_DE_LEN     = DE_BURST[4:0];
    localparam logic [c_SW-1:0]   c_STARVE_MAX = STARVE[c_SW-1:0];

    logic [1:0]      state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [4:0]      len_q, len_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [c_SW-1:0] starve_q, starve_d;
    logic            abort_q, abort_d;

    logic            crt_gnt_q, crt_gnt_d;
    logic            cpu_gnt_q, cpu_gnt_d;
    logic            de_gnt_q, de_gnt_d;
    logic            mem_start_q, mem_start_d;
    logic [4:0]      mem_len_q, mem_len_d;
    logic            crt_ff_write_q, crt_ff_write_d;
    logic            burst_done_q, burst_done_d;
    logic            busy_q, busy_d;

    logic [1:0]      w_winner;
    logic            w_abort_set;

    // A line end seen while idle suppresses any CRT win for that cycle only.
    always_comb begin
        w_winner = c_OWN_NONE;
        if (bus.crt_urgent && !bus.sync_crt_line_end) begin
            w_winner = c_OWN_CRT;
        end else if (bus.de_req && (starve_q >= c_STARVE_MAX)) begin
            w_winner = c_OWN_DE;
        end else if (bus.cpu_req) begin
            w_winner = c_OWN_CPU;
        end else if (bus.crt_req && !bus.sync_crt_line_end) begin
            w_winner = c_OWN_CRT;
        end else if (bus.de_req) begin
            w_winner = c_OWN_DE;
        end
    end

    assign w_abort_set = bus.sync_crt_line_end && (owner_q == c_OWN_CRT) &&
                         ((state_q == c_START) || (state_q == c_XFER));

    always_ff @(posedge mem_clk or posedge hreset) begin
        if (hreset) begin
            state_q        <= c_IDLE;
            owner_q        <= c_OWN_NONE;
            len_q          <= 5'd0;
            cnt_q          <= 5'd0;
            starve_q       <= '0;
            abort_q        <= 1'b0;
            crt_gnt_q      <= 1'b0;
            cpu_gnt_q      <= 1'b0;
            de_gnt_q       <= 1'b0;
            mem_start_q    <= 1'b0;
            mem_len_q      <= 5'd0;
            crt_ff_write_q <= 1'b0;
            burst_done_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            starve_q       <= starve_d;
            abort_q        <= abort_d;
            crt_gnt_q      <= crt_gnt_d;
            cpu_gnt_q      <= cpu_gnt_d;
            de_gnt_q       <= de_gnt_d;
            mem_start_q    <= mem_start_d;
            mem_len_q      <= mem_len_d;
            crt_ff_write_q <= crt_ff_write_d;
            burst_done_q   <= burst_done_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        case (state_q)
            c_IDLE: begin
                cnt_d   = 5'd0;
                abort_d = 1'b0;
                if (w_winner != c_OWN_NONE) begin
                    state_d = c_START;
                    owner_d = w_winner;
                    case (w_winner)
                        c_OWN_CRT: len_d = c_CRT_LEN;
                        c_OWN_DE:  len_d = c_DE_LEN;
                        default:   len_d = 5'd1;
                    endcase
                end
            end
            c_START: begin
                if (w_abort_set) begin
                    abort_d = 1'b1;
                end
                if (bus.mem_rdy) begin
                    state_d = c_XFER;
                end
            end
            c_XFER: begin
                if (w_abort_set) begin
                    abort_d = 1'b1;
                end
                if (bus.mem_dval) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == (len_q - 5'd1)) begin
                        state_d = c_DONE;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                owner_d = c_OWN_NONE;
                abort_d = 1'b0;
            end
        endcase

        // Starvation age of a pending DE request; frozen at zero while DE owns the bus.
        starve_d = starve_q;
        if (!bus.de_req) begin
            starve_d = '0;
        end else if ((state_q == c_IDLE) && (w_winner == c_OWN_DE)) begin
            starve_d = '0;
        end else if (owner_q == c_OWN_DE) begin
            starve_d = '0;
        end else if (starve_q < c_STARVE_MAX) begin
            starve_d = starve_q + c_SW'(1);
        end
    end

    always_comb begin
        crt_gnt_d      = (state_d != c_IDLE) && (owner_d == c_OWN_CRT);
        cpu_gnt_d      = (state_d != c_IDLE) && (owner_d == c_OWN_CPU);
        de_gnt_d       = (state_d != c_IDLE) && (owner_d == c_OWN_DE);
        mem_start_d    = (state_q == c_START) && bus.mem_rdy;
        mem_len_d      = mem_start_d ? len_q : 5'd0;
        crt_ff_write_d = (state_q == c_XFER) && bus.mem_dval && (owner_q == c_OWN_CRT) &&
                         !abort_q && !w_abort_set;
        burst_done_d   = (state_d == c_DONE);
        busy_d         = (state_d != c_IDLE);
    end

    assign bus.crt_gnt      = crt_gnt_q;
    assign bus.cpu_gnt      = cpu_gnt_q;
    assign bus.de_gnt       = de_gnt_q;
    assign bus.mem_start    = mem_start_q;
    assign bus.mem_len      = mem_len_q;
    assign bus.crt_ff_write = crt_ff_write_q;
    assign bus.burst_done   = burst_done_q;
    assign bus.busy         = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_crt_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_crt_mem_arb
// Brief    : Self-checking bench for crt_mem_arb with a transaction-level
//            priority / starvation reference model.
// Revision : 1.0
// ============================================================================
module tb_crt_mem_arb;
    localparam int CRT_BURST = 16;
    localparam int DE_BURST  = 8;
    localparam int STARVE    = 32;
    localparam int OWN_NONE  = 0;
    localparam int OWN_CRT   = 1;
    localparam int OWN_CPU   = 2;
    localparam int OWN_DE    = 3;

    logic mem_clk   = 1'b0;
    logic hreset    = 1'b1;
    int   errors    = 0;
    int   checks    = 0;
    int   m_starve  = 0;
    bit   m_de_owns = 1'b0;
    int   own;
    int   abort_at;

    crt_mem_arb_if bus ();

    crt_mem_arb #(
        .CRT_BURST (CRT_BURST),
        .DE_BURST  (DE_BURST),
        .STARVE    (STARVE)
    ) dut (
        .mem_clk (mem_clk),
        .hreset  (hreset),
        .bus     (bus)
    );

    always #5 mem_clk = ~mem_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model ages the DE request exactly as the rules describe.
    task automatic tick();
        @(posedge mem_clk);
        if (hreset || !bus.de_req || m_de_owns) m_starve = 0;
        else if (m_starve < STARVE)              m_starve = m_starve + 1;
        #1;
    endtask

    function automatic logic [2:0] gnt_obs();
        return {bus.crt_gnt, bus.cpu_gnt, bus.de_gnt};
    endfunction

    function automatic logic [2:0] gnt_vec(input int o);
        case (o)
            OWN_CRT: return 3'b100;
            OWN_CPU: return 3'b010;
            OWN_DE:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int exp_winner();
        if (bus.crt_urgent && !bus.sync_crt_line_end)     return OWN_CRT;
        if (bus.de_req && (m_starve >= STARVE))           return OWN_DE;
        if (bus.cpu_req)                                  return OWN_CPU;
        if (bus.crt_req && !bus.sync_crt_line_end)        return OWN_CRT;
        if (bus.de_req)                                   return OWN_DE;
        return OWN_NONE;
    endfunction

    function automatic int exp_len(input int o);
        if (o == OWN_CRT) return CRT_BURST;
        if (o == OWN_DE)  return DE_BURST;
        return 1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt_obs()), 32'd0);
        chk({tag, "_start"}, 32'(bus.mem_start), 32'd0);
        chk({tag, "_len"},   32'(bus.mem_len), 32'd0);
        chk({tag, "_wr"},    32'(bus.crt_ff_write), 32'd0);
        chk({tag, "_done"},  32'(bus.burst_done), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
    endtask

    // One arbitration and, if anything wins, the complete burst that follows.
    task automatic burst(input bit drop, input bit rerand, input int rdy_wait,
                         input int abort_after, output int o);
        int len, words, writes, exp_wr, gap, ab;
        bit pulsed;
        o = exp_winner();
        m_de_owns = (o == OWN_DE);
        bus.mem_rdy  = 1'b0;
        bus.mem_dval = ($urandom_range(0, 1) == 1);
        tick();
        chk("arb_gnt", 32'(gnt_obs()), 32'(gnt_vec(o)));
        bus.sync_crt_line_end = 1'b0;
        if (o == OWN_NONE) begin
            chk("arb_busy", 32'(bus.busy), 32'd0);
            return;
        end
        chk("start_busy", 32'(bus.busy), 32'd1);
        len = exp_len(o);
        ab  = (o == OWN_CRT) ? abort_after : -1;
        if (rerand) begin
            bus.crt_urgent = 1'b0;
            bus.cpu_req    = ($urandom_range(0, 1) == 1);
            bus.crt_req    = ($urandom_range(0, 1) == 1);
            bus.de_req     = ($urandom_range(0, 1) == 1);
        end
        if (drop) begin
            if (o == OWN_CRT) begin bus.crt_req = 1'b0; bus.crt_urgent = 1'b0; end
            if (o == OWN_CPU) bus.cpu_req = 1'b0;
            if (o == OWN_DE)  bus.de_req  = 1'b0;
        end
        for (int i = 0; i < rdy_wait; i++) begin
            bus.mem_rdy  = 1'b0;
            bus.mem_dval = ($urandom_range(0, 1) == 1);
            tick();
            chk("wait_start", 32'(bus.mem_start), 32'd0);
            chk("wait_gnt", 32'(gnt_obs()), 32'(gnt_vec(o)));
            chk("wait_wr", 32'(bus.crt_ff_write), 32'd0);
        end
        bus.mem_rdy  = 1'b1;
        bus.mem_dval = ($urandom_range(0, 1) == 1);
        tick();
        chk("mem_start", 32'(bus.mem_start), 32'd1);
        chk("mem_len", 32'(bus.mem_len), 32'(len));
        chk("start_wr", 32'(bus.crt_ff_write), 32'd0);
        bus.mem_rdy = ($urandom_range(0, 1) == 1);
        words = 0; writes = 0; gap = 0; pulsed = 1'b0;
        while (words < len) begin
            if (!pulsed && (ab >= 0) && (words == ab)) begin
                bus.sync_crt_line_end = 1'b1;
                bus.mem_dval          = 1'b0;
                pulsed                = 1'b1;
            end else begin
                bus.sync_crt_line_end = 1'b0;
                bus.mem_dval          = (gap >= 3) || ($urandom_range(0, 3) != 0);
            end
            if (bus.mem_dval) begin words++; gap = 0; end
            else gap++;
            tick();
            writes += int'(bus.crt_ff_write);
            chk("xfer_start_low", 32'(bus.mem_start), 32'd0);
            chk("done_flag", 32'(bus.burst_done), 32'(words == len));
            chk("xfer_gnt", 32'(gnt_obs()), 32'(gnt_vec(o)));
        end
        bus.mem_dval          = 1'b0;
        bus.sync_crt_line_end = 1'b0;
        exp_wr = (o != OWN_CRT) ? 0 : ((ab >= 0) ? ab : len);
        chk("wr_count", 32'(writes), 32'(exp_wr));
        chk("done_busy", 32'(bus.busy), 32'd1);
        tick();
        m_de_owns = 1'b0;
        chk_zero("post_done");
    endtask

    initial begin
        bus.crt_req = 1'b1; bus.crt_urgent = 1'b0; bus.sync_crt_line_end = 1'b0;
        bus.cpu_req = 1'b1; bus.de_req = 1'b1; bus.mem_rdy = 1'b1; bus.mem_dval = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero("reset");
        end
        // Single CRT refill straight out of reset.
        hreset = 1'b0;
        bus.cpu_req = 1'b0; bus.de_req = 1'b0; bus.crt_req = 1'b1;
        burst(1'b1, 1'b0, 0, -1, own);

        // All three requesters together.
        bus.cpu_req = 1'b1; bus.crt_req = 1'b1; bus.de_req = 1'b1;
        for (int i = 0; i < 3; i++) burst(1'b1, 1'b0, 0, -1, own);

        // Memory not ready for ten cycles.
        bus.crt_req = 1'b1;
        burst(1'b1, 1'b0, 10, -1, own);

        // Line end after the fifth word, then a clean CRT refill.
        bus.crt_req = 1'b1;
        burst(1'b1, 1'b0, 0, 5, own);
        bus.crt_req = 1'b1;
        burst(1'b1, 1'b0, 1, -1, own);

        // Line end while idle blocks CRT for one cycle.
        bus.crt_req = 1'b1; bus.sync_crt_line_end = 1'b1;
        burst(1'b0, 1'b0, 0, -1, own);
        burst(1'b1, 1'b0, 0, -1, own);
        bus.crt_urgent = 1'b1; bus.cpu_req = 1'b1; bus.sync_crt_line_end = 1'b1;
        burst(1'b1, 1'b0, 0, -1, own);
        bus.crt_urgent = 1'b1; bus.cpu_req = 1'b1;
        burst(1'b1, 1'b0, 0, -1, own);
        bus.cpu_req = 1'b0; bus.crt_req = 1'b0; bus.crt_urgent = 1'b0;

        // DE starved behind a continuous CPU stream.
        bus.de_req = 1'b1; bus.cpu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            burst(1'b0, 1'b0, $urandom_range(0, 1), -1, own);
            if (own == OWN_DE) break;
        end
        chk("starve_clear", 32'(dut.starve_q), 32'd0);
        bus.de_req = 1'b0; bus.cpu_req = 1'b0;

        // Randomized request mixes.
        for (int n = 0; n < 25; n++) begin
            bus.crt_urgent        = ($urandom_range(0, 7) == 0);
            bus.cpu_req           = ($urandom_range(0, 1) == 1);
            bus.crt_req           = ($urandom_range(0, 1) == 1);
            bus.de_req            = ($urandom_range(0, 1) == 1);
            bus.sync_crt_line_end = ($urandom_range(0, 7) == 0);
            abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            burst(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                  int'($urandom_range(0, 3)), abort_at, own);
        end
        bus.crt_urgent = 1'b0; bus.cpu_req = 1'b0; bus.crt_req = 1'b0;
        bus.de_req = 1'b0; bus.sync_crt_line_end = 1'b0;
        tick();
        tick();

        // Reset pulsed in the middle of a CRT transfer.
        bus.crt_req = 1'b1; bus.mem_rdy = 1'b0; bus.mem_dval = 1'b0;
        tick();
        chk("rst_arb_gnt", 32'(gnt_obs()), 32'(gnt_vec(OWN_CRT)));
        bus.crt_req = 1'b0; bus.mem_rdy = 1'b1;
        tick();
        chk("rst_mem_start", 32'(bus.mem_start), 32'd1);
        bus.mem_dval = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        hreset = 1'b1;
        #1;
        chk_zero("rst_async");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_zero("rst_hold");
        end
        hreset = 1'b0; bus.mem_dval = 1'b0; m_de_owns = 1'b0;
        bus.crt_req = 1'b1;
        burst(1'b1, 1'b0, 0, -1, own);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
